// File: rtl/mips32_fetch_queue_if.sv
// Fetch-queue bus bundle: instruction-memory req/ack channel plus the
// valid/ready channel that hands {IR, NPC} pairs to the ID stage.
// master = fetch queue side, slave = memory/ID side.
interface mips32_fetch_queue_if #(
  parameter int ADDR_W = 10
);

  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [31:0]       imem_rdata;

  logic              id_valid;
  logic              id_ready;
  logic [31:0]       id_ir;
  logic [ADDR_W-1:0] id_npc;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata,
    output id_valid,
    input  id_ready,
    output id_ir,
    output id_npc
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata,
    input  id_valid,
    output id_ready,
    input  id_ir,
    input  id_npc
  );

endinterface

// File: rtl/mips32_fetch_queue.sv
// MIPS32 instruction-fetch front end. Fetches words over a req/ack handshake,
// buffers {IR, NPC} pairs in a DEPTH-entry FIFO and presents the head to ID.
// A taken-branch redirect flushes the FIFO and restarts fetch at the target;
// a request already in flight at that moment is allowed to finish and its
// data is thrown away.
// Optional feature: define FQ_HLT_STOP_EN to stop fetching after a HLT word
// (opcode 6'b111111) has been queued, until the next redirect or reset.
module mips32_fetch_queue #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 10
) (
  input  logic                     clk1,
  input  logic                     rst_n,
  mips32_fetch_queue_if.master     bus,
  input  logic                     redirect_valid_i,
  input  logic [ADDR_W-1:0]        redirect_pc_i,
  input  logic                     halted_i,
  output logic [$clog2(DEPTH):0]   fill_count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              req_q, req_d;
  logic              stop_q, stop_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic [31:0]       ir_mem_q  [DEPTH];
  logic [ADDR_W-1:0] npc_mem_q [DEPTH];

  logic              push;
  logic              flush;
  logic              pop_en;
  logic              is_hlt;
  logic [ADDR_W-1:0] pc_inc;

  assign pc_inc = pc_q + 1'b1;
  assign pop_en = (count_q != '0) && bus.id_ready && !redirect_valid_i;

`ifdef FQ_HLT_STOP_EN
  assign is_hlt = (bus.imem_rdata[31:26] == 6'b111111);
`else
  assign is_hlt = 1'b0;
`endif

  // Fetch FSM: issue one request at a time, retire it on ack, and squash it on redirect.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    req_d   = req_q;
    stop_d  = stop_q;
    push    = 1'b0;
    flush   = 1'b0;

    case (state_q)
      IDLE: begin
        if (redirect_valid_i) begin
          pc_d  = redirect_pc_i;
          flush = 1'b1;
        end else if (!halted_i && (count_q < DEPTH_C) && !stop_q) begin
          req_d   = 1'b1;
          addr_d  = pc_q;
          state_d = WAIT;
        end
      end

      WAIT: begin
        if (redirect_valid_i) begin
          pc_d  = redirect_pc_i;
          flush = 1'b1;
          if (bus.imem_ack) begin
            req_d   = 1'b0;
            state_d = IDLE;
          end else begin
            state_d = DROP;
          end
        end else if (bus.imem_ack) begin
          push    = 1'b1;
          pc_d    = pc_inc;
          req_d   = 1'b0;
          state_d = IDLE;
          if (is_hlt) begin
            stop_d = 1'b1;
          end
        end
      end

      DROP: begin
        if (redirect_valid_i) begin
          pc_d  = redirect_pc_i;
          flush = 1'b1;
        end
        if (bus.imem_ack) begin
          req_d   = 1'b0;
          state_d = IDLE;
        end
      end

      default: begin
        req_d   = 1'b0;
        state_d = IDLE;
      end
    endcase

    if (redirect_valid_i) begin
      stop_d = 1'b0;
    end
  end

  // FIFO bookkeeping: flush wins, otherwise push/pop move the pointers and count.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop_en) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push, pop_en})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Control and pointer state registers.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      pc_q     <= '0;
      addr_q   <= '0;
      req_q    <= 1'b0;
      stop_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      addr_q   <= addr_d;
      req_q    <= req_d;
      stop_q   <= stop_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // FIFO storage; cleared on reset so the presented head reads as zero.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        ir_mem_q[i]  <= '0;
        npc_mem_q[i] <= '0;
      end
    end else if (push) begin
      ir_mem_q[wr_ptr_q]  <= bus.imem_rdata;
      npc_mem_q[wr_ptr_q] <= pc_inc;
    end
  end

  assign bus.imem_req  = req_q;
  assign bus.imem_addr = addr_q;
  assign bus.id_valid  = (count_q != '0);
  assign bus.id_ir     = ir_mem_q[rd_ptr_q];
  assign bus.id_npc    = npc_mem_q[rd_ptr_q];
  assign fill_count_o  = count_q;

endmodule

// File: tb/tb_mips32_fetch_queue.sv
// Self-checking bench for mips32_fetch_queue: a memory responder answers
// fetch requests, and a monitor compares every new request address and
// every word accepted by ID against queues of hand-computed expectations.
// Build with +define+FQ_HLT_STOP_EN to exercise the HLT-stop variant.
module tb_mips32_fetch_queue;

   localparam int DEPTH  = 4;
   localparam int ADDR_W = 10;

   typedef struct {
      logic [31:0]       ir;
      logic [ADDR_W-1:0] npc;
   } idExp_t;

   logic              clk1 = 1'b0;
   logic              rst_n = 1'b0;
   logic              redirectValid = 1'b0;
   logic [ADDR_W-1:0] redirectPc = '0;
   logic              halted = 1'b1;
   logic [2:0]        fillCount;

   logic              ackEn = 1'b0;
   int                ackDelay = 0;
   int                waitCnt = 0;
   logic              reqPrev = 1'b0;

   logic [31:0]       mem [1024];
   idExp_t            expId[$];
   logic [ADDR_W-1:0] expAddr[$];

   int                total = 0;
   int                bad = 0;

   mips32_fetch_queue_if #(.ADDR_W(ADDR_W)) bus ();

   mips32_fetch_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
      .clk1             (clk1),
      .rst_n            (rst_n),
      .bus              (bus),
      .redirect_valid_i (redirectValid),
      .redirect_pc_i    (redirectPc),
      .halted_i         (halted),
      .fill_count_o     (fillCount)
   );

   // Free-running clock, period 10.
   always #5 clk1 = ~clk1;

   // One comparison: count it, and report a FAIL line if it does not match.
   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
      end
   endtask

   // Set the core-side level inputs directly at the current time.
   task automatic applyStimulus(input logic haltIn, input logic readyIn);
      halted = haltIn;
      bus.id_ready = readyIn;
   endtask

   task automatic waitCycles(input int n);
      repeat (n) @(posedge clk1);
      #2;
   endtask

   // One-cycle taken-branch redirect.
   task automatic applyRedirect(input logic [ADDR_W-1:0] target);
      redirectValid = 1'b1;
      redirectPc = target;
      waitCycles(1);
      redirectValid = 1'b0;
   endtask

   task automatic applyReset();
      halted = 1'b1;
      rst_n = 1'b0;
      waitCycles(2);
      rst_n = 1'b1;
      waitCycles(1);
   endtask

   // Let the queue issue exactly n requests, then hold it with halted.
   task automatic fetchWords(input int n);
      int cnt = 0;
      logic prev;
      prev = bus.imem_req;
      halted = 1'b0;
      for (int c = 0; c < 200 && cnt < n; c++) begin
         @(posedge clk1);
         #2;
         if (bus.imem_req && !prev) cnt++;
         prev = bus.imem_req;
      end
      halted = 1'b1;
      checkOutput("fetchCount", 32'(cnt), 32'(n));
   endtask

   // Let ID accept everything until the expectation queue and the DUT are empty.
   task automatic waitDrain();
      int c = 0;
      bus.id_ready = 1'b1;
      while (c < 200 && !(expId.size() == 0 && !bus.id_valid && !bus.imem_req)) begin
         waitCycles(1);
         c++;
      end
      checkOutput("drainLeft", 32'(expId.size()), 32'd0);
   endtask

   task automatic pushId(input logic [31:0] ir, input logic [ADDR_W-1:0] npc);
      idExp_t e;
      e.ir = ir;
      e.npc = npc;
      expId.push_back(e);
   endtask

   // Instruction memory: acknowledges a pending request after ackDelay cycles.
   initial begin
      bus.imem_ack = 1'b0;
      bus.imem_rdata = '0;
      forever begin
         @(negedge clk1);
         if (!rst_n) begin
            bus.imem_ack = 1'b0;
            waitCnt = 0;
         end else if (bus.imem_ack) begin
            bus.imem_ack = 1'b0;
         end else if (bus.imem_req && ackEn) begin
            if (waitCnt >= ackDelay) begin
               bus.imem_ack = 1'b1;
               bus.imem_rdata = mem[bus.imem_addr];
               waitCnt = 0;
            end else begin
               waitCnt++;
            end
         end else if (!bus.imem_req) begin
            waitCnt = 0;
         end
      end
   end

   // Monitor: checks each new request address and each word taken by ID.
   initial begin
      idExp_t e;
      logic [ADDR_W-1:0] a;
      forever begin
         @(negedge clk1);
         if (rst_n) begin
            if (bus.imem_req && !reqPrev) begin
               if (expAddr.size() == 0) begin
                  checkOutput("reqUnexpected", 32'(bus.imem_addr), 32'hffffffff);
               end else begin
                  a = expAddr.pop_front();
                  checkOutput("reqAddr", 32'(bus.imem_addr), 32'(a));
               end
            end
            if (bus.id_valid && bus.id_ready && !redirectValid) begin
               if (expId.size() == 0) begin
                  checkOutput("idUnexpected", bus.id_ir, 32'hffffffff);
               end else begin
                  e = expId.pop_front();
                  checkOutput("idIr", bus.id_ir, e.ir);
                  checkOutput("idNpc", 32'(bus.id_npc), 32'(e.npc));
               end
            end
         end
         reqPrev = rst_n ? bus.imem_req : 1'b0;
      end
   end

   // Watchdog so the bench can never hang.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] timeout");
   end

   // Directed scenarios.
   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = 32'h0c000000 | 32'(i);
      mem[0] = 32'h280a00c8;
      mem[1] = 32'h28020001;
      mem[10] = 32'hfc000000;
      bus.id_ready = 1'b0;

      // Reset values.
      waitCycles(2);
      checkOutput("rstReq", 32'(bus.imem_req), 32'd0);
      checkOutput("rstAddr", 32'(bus.imem_addr), 32'd0);
      checkOutput("rstValid", 32'(bus.id_valid), 32'd0);
      checkOutput("rstIr", bus.id_ir, 32'd0);
      checkOutput("rstNpc", 32'(bus.id_npc), 32'd0);
      checkOutput("rstFill", 32'(fillCount), 32'd0);
      rst_n = 1'b1;
      waitCycles(1);

      // Reset in the middle of a stalled fetch.
      ackEn = 1'b0;
      expAddr.push_back(10'd0);
      applyStimulus(1'b0, 1'b0);
      waitCycles(3);
      checkOutput("midWaitReq", 32'(bus.imem_req), 32'd1);
      #1;
      rst_n = 1'b0;
      #1;
      checkOutput("midRstReq", 32'(bus.imem_req), 32'd0);
      checkOutput("midRstAddr", 32'(bus.imem_addr), 32'd0);
      checkOutput("midRstValid", 32'(bus.id_valid), 32'd0);
      checkOutput("midRstFill", 32'(fillCount), 32'd0);
      checkOutput("midRstIr", bus.id_ir, 32'd0);
      halted = 1'b1;
      waitCycles(1);
      rst_n = 1'b1;
      waitCycles(1);

      // Two words in order with 1-cycle ack and ID always ready.
      ackEn = 1'b1;
      ackDelay = 0;
      bus.id_ready = 1'b1;
      expAddr.push_back(10'd0);
      expAddr.push_back(10'd1);
      pushId(32'h280a00c8, 10'd1);
      pushId(32'h28020001, 10'd2);
      fetchWords(2);
      waitDrain();
      checkOutput("twoWordsFill", 32'(fillCount), 32'd0);

      // ID stalled: exactly DEPTH words fetched, then one pop frees one slot.
      applyReset();
      for (int i = 0; i < 4; i++) expAddr.push_back(ADDR_W'(i));
      applyStimulus(1'b0, 1'b0);
      waitCycles(20);
      checkOutput("fullFill", 32'(fillCount), 32'd4);
      checkOutput("fullReq", 32'(bus.imem_req), 32'd0);
      checkOutput("fullValid", 32'(bus.id_valid), 32'd1);
      checkOutput("fullHeadIr", bus.id_ir, 32'h280a00c8);
      pushId(32'h280a00c8, 10'd1);
      expAddr.push_back(10'd4);
      bus.id_ready = 1'b1;
      waitCycles(1);
      bus.id_ready = 1'b0;
      waitCycles(10);
      checkOutput("refillFill", 32'(fillCount), 32'd4);
      checkOutput("refillReq", 32'(bus.imem_req), 32'd0);
      halted = 1'b1;
      pushId(32'h28020001, 10'd2);
      pushId(32'h0c000002, 10'd3);
      pushId(32'h0c000003, 10'd4);
      pushId(32'h0c000004, 10'd5);
      waitDrain();
      checkOutput("stallDrainFill", 32'(fillCount), 32'd0);

      // Redirect to 5 while waiting on addr 9, with two words queued.
      bus.id_ready = 1'b0;
      applyRedirect(10'd7);
      expAddr.push_back(10'd7);
      expAddr.push_back(10'd8);
      fetchWords(2);
      waitCycles(4);
      checkOutput("preFlushFill", 32'(fillCount), 32'd2);
      ackEn = 1'b0;
      expAddr.push_back(10'd9);
      fetchWords(1);
      waitCycles(2);
      applyRedirect(10'd5);
      checkOutput("flushFill", 32'(fillCount), 32'd0);
      checkOutput("flushValid", 32'(bus.id_valid), 32'd0);
      checkOutput("dropReqHeld", 32'(bus.imem_req), 32'd1);
      checkOutput("dropAddrHeld", 32'(bus.imem_addr), 32'd9);
      ackEn = 1'b1;
      waitCycles(3);
      checkOutput("dropDoneReq", 32'(bus.imem_req), 32'd0);
      checkOutput("dropDoneFill", 32'(fillCount), 32'd0);
      expAddr.push_back(10'd5);
      pushId(32'h0c000005, 10'd6);
      fetchWords(1);
      waitDrain();

      // Redirect, ack and pop all in the same cycle.
      bus.id_ready = 1'b0;
      expAddr.push_back(10'd6);
      fetchWords(1);
      waitCycles(3);
      checkOutput("triFillBefore", 32'(fillCount), 32'd1);
      ackEn = 1'b0;
      expAddr.push_back(10'd7);
      fetchWords(1);
      waitCycles(1);
      ackEn = 1'b1;
      redirectValid = 1'b1;
      redirectPc = 10'd20;
      bus.id_ready = 1'b1;
      waitCycles(1);
      redirectValid = 1'b0;
      bus.id_ready = 1'b0;
      checkOutput("triFill", 32'(fillCount), 32'd0);
      checkOutput("triReq", 32'(bus.imem_req), 32'd0);
      expAddr.push_back(10'd20);
      pushId(32'h0c000014, 10'd21);
      fetchWords(1);
      waitDrain();

      // HLT word at addr 10.
      applyRedirect(10'd10);
`ifdef FQ_HLT_STOP_EN
      expAddr.push_back(10'd10);
      pushId(32'hfc000000, 10'd11);
      applyStimulus(1'b0, 1'b1);
      waitCycles(20);
      checkOutput("hltReq", 32'(bus.imem_req), 32'd0);
      halted = 1'b1;
      checkOutput("hltFill", 32'(fillCount), 32'd0);
      applyRedirect(10'd12);
      expAddr.push_back(10'd12);
      pushId(32'h0c00000c, 10'd13);
      fetchWords(1);
      waitDrain();
`else
      expAddr.push_back(10'd10);
      expAddr.push_back(10'd11);
      pushId(32'hfc000000, 10'd11);
      pushId(32'h0c00000b, 10'd12);
      bus.id_ready = 1'b1;
      fetchWords(2);
      waitDrain();
`endif

      // pc wrap at the top of the address space.
      applyRedirect(10'd1023);
      expAddr.push_back(10'd1023);
      expAddr.push_back(10'd0);
      pushId(32'h0c0003ff, 10'd0);
      pushId(32'h280a00c8, 10'd1);
      bus.id_ready = 1'b1;
      fetchWords(2);
      waitDrain();

      waitCycles(2);
      checkOutput("expAddrLeft", 32'(expAddr.size()), 32'd0);
      checkOutput("expIdLeft", 32'(expId.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
